// File: rtl/joy_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared definitions for the joystick direction conditioner.
//   DIR_*      bit positions inside a 4-bit direction nibble {up,down,left,right}
//   dir_t      one channel's direction nibble
//   act_t      which direction currently owns a 4-way channel
//   rot90      90-degree rotation of a nibble
//   prio_pick  one-hot of the highest-priority set bit (up>down>left>right)
//   act_from_onehot / act_onehot  conversions between act_t and a one-hot nibble
// -----------------------------------------------------------------------------
package joy_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef logic [3:0] dir_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } act_t;

    // Rotated cabinet: up<-left, down<-right, left<-down, right<-up.
    function automatic dir_t rot90(dir_t d);
        dir_t r;
        r            = '0;
        r[DIR_UP]    = d[DIR_LEFT];
        r[DIR_DOWN]  = d[DIR_RIGHT];
        r[DIR_LEFT]  = d[DIR_DOWN];
        r[DIR_RIGHT] = d[DIR_UP];
        return r;
    endfunction

    function automatic dir_t prio_pick(dir_t d);
        dir_t r;
        r = '0;
        if (d[DIR_UP])          r[DIR_UP]    = 1'b1;
        else if (d[DIR_DOWN])   r[DIR_DOWN]  = 1'b1;
        else if (d[DIR_LEFT])   r[DIR_LEFT]  = 1'b1;
        else if (d[DIR_RIGHT])  r[DIR_RIGHT] = 1'b1;
        return r;
    endfunction

    function automatic act_t act_from_onehot(dir_t oh);
        act_t a;
        a = ACT_NONE;
        if (oh[DIR_UP])          a = ACT_UP;
        else if (oh[DIR_DOWN])   a = ACT_DOWN;
        else if (oh[DIR_LEFT])   a = ACT_LEFT;
        else if (oh[DIR_RIGHT])  a = ACT_RIGHT;
        return a;
    endfunction

    function automatic dir_t act_onehot(act_t a);
        dir_t r;
        r = '0;
        case (a)
            ACT_UP:    r[DIR_UP]    = 1'b1;
            ACT_DOWN:  r[DIR_DOWN]  = 1'b1;
            ACT_LEFT:  r[DIR_LEFT]  = 1'b1;
            ACT_RIGHT: r[DIR_RIGHT] = 1'b1;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// -----------------------------------------------------------------------------
// joy_dir_chan
// One joystick channel: optional rotation, 2-flop synchroniser, per-bit
// debounce, 4-way newest-press-wins / 8-way opposite-cancel filter, and a
// one-clock change pulse.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_ce       debounce tick enable
//   i_mode8    0 = 4-way, 1 = 8-way
//   i_rotate   1 = rotate the raw nibble by 90 degrees
//   i_dir      raw {up,down,left,right}, active-high
//   o_dir      conditioned direction, registered
//   o_changed  one-clock pulse whenever o_dir changes
// -----------------------------------------------------------------------------
module joy_dir_chan
    import joy_pkg::*;
#(
    parameter int DEB_CNT = 1023,
    parameter int DEB_W   = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ce,
    input  logic i_mode8,
    input  logic i_rotate,
    input  dir_t i_dir,
    output dir_t o_dir,
    output logic o_changed
);

    // Guard against DEB_CNT = 0 so the compare constant stays in range.
    localparam int              DEB_LAST_I = (DEB_CNT > 0) ? DEB_CNT - 1 : 0;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_LAST_I);

    dir_t             w_rot;
    dir_t             r_sync1;
    dir_t             r_sync2;
    dir_t             r_stable;
    dir_t             r_stable_d;
    logic [DEB_W-1:0] r_cnt [4];
    act_t             r_active;
    act_t             w_active_next;
    dir_t             w_rise;
    dir_t             w_dir_next;
    dir_t             w_cancel;
    dir_t             r_dir;
    logic             r_changed;

    assign w_rot = i_rotate ? rot90(i_dir) : i_dir;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_rot;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted only after it has differed from stable for DEB_CNT
    // consecutive ce ticks; returning to the stable value clears the count,
    // so the counter never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= '0;
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_sync2[b] == r_stable[b]) begin
                    r_cnt[b] <= '0;
                end else if (DEB_CNT == 0) begin
                    r_stable[b] <= r_sync2[b];
                end else if (i_ce) begin
                    if (r_cnt[b] == DEB_LAST) begin
                        r_stable[b] <= r_sync2[b];
                        r_cnt[b]    <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d <= '0;
            r_active   <= ACT_NONE;
        end else begin
            r_stable_d <= r_stable;
            r_active   <= w_active_next;
        end
    end

    // Newest press wins; when the owner is released (or there is no owner)
    // fall back to the highest-priority direction still held. The owner is
    // tracked in 8-way mode too so a mode switch picks up seamlessly.
    always_comb begin
        w_active_next = r_active;
        if (w_rise != '0) begin
            w_active_next = act_from_onehot(prio_pick(w_rise));
        end else if ((act_onehot(r_active) & r_stable) == '0) begin
            w_active_next = act_from_onehot(prio_pick(r_stable));
        end
    end

    always_comb begin
        w_cancel = r_stable;
        if (r_stable[DIR_UP] && r_stable[DIR_DOWN]) begin
            w_cancel[DIR_UP]   = 1'b0;
            w_cancel[DIR_DOWN] = 1'b0;
        end
        if (r_stable[DIR_LEFT] && r_stable[DIR_RIGHT]) begin
            w_cancel[DIR_LEFT]  = 1'b0;
            w_cancel[DIR_RIGHT] = 1'b0;
        end
    end

    // Output uses the next owner so a rise shows up on the same edge it is seen.
    assign w_dir_next = i_mode8 ? w_cancel : (act_onehot(w_active_next) & r_stable);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dir     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_dir     <= w_dir_next;
            r_changed <= (w_dir_next != r_dir);
        end
    end

    assign o_dir     = r_dir;
    assign o_changed = r_changed;

endmodule

// File: rtl/joy_dir_arbiter.sv
// -----------------------------------------------------------------------------
// joy_dir_arbiter
// Multi-channel joystick direction conditioner. Each channel is an independent
// joy_dir_chan; there is no interaction between channels.
// Ports:
//   clk_sys   system clock
//   reset_n   asynchronous active-low reset
//   ce        debounce tick enable
//   mode8     0 = 4-way, 1 = 8-way (all channels)
//   rotate    1 = rotate all channels by 90 degrees
//   dir_in    raw dirs, channel c at [4c+3:4c] = {up,down,left,right}
//   dir_out   conditioned dirs, same packing, registered
//   changed   per-channel one-clock pulse when that channel's dir_out changes
// -----------------------------------------------------------------------------
module joy_dir_arbiter
    import joy_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DEB_CNT = 1023,
    parameter int DEB_W   = 10
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  mode8,
    input  logic                  rotate,
    input  logic [NUM_CH*4-1:0]   dir_in,
    output logic [NUM_CH*4-1:0]   dir_out,
    output logic [NUM_CH-1:0]     changed
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        joy_dir_chan #(
            .DEB_CNT (DEB_CNT),
            .DEB_W   (DEB_W)
        ) u_chan (
            .i_clk     (clk_sys),
            .i_rst_n   (reset_n),
            .i_ce      (ce),
            .i_mode8   (mode8),
            .i_rotate  (rotate),
            .i_dir     (dir_in[4*c +: 4]),
            .o_dir     (dir_out[4*c +: 4]),
            .o_changed (changed[c])
        );
    end

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// -----------------------------------------------------------------------------
// tb_joy_dir_arbiter
// Two instances share all inputs: one with debounce bypassed, one with a
// 4-tick debounce. A behavioural model of each is stepped every clock and the
// registered outputs are compared after every edge, with directed scenarios
// followed by random traffic.
// -----------------------------------------------------------------------------
module tb_joy_dir_arbiter;

    localparam int NCH = 2;

    logic             clk_sys = 1'b0;
    logic             reset_n;
    logic             ce;
    logic             mode8;
    logic             rotate;
    logic [NCH*4-1:0] dir_in;
    logic [NCH*4-1:0] out0;
    logic [NCH*4-1:0] out4;
    logic [NCH-1:0]   chg0;
    logic [NCH-1:0]   chg4;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk_sys = ~clk_sys;

    joy_dir_arbiter #(.NUM_CH(NCH), .DEB_CNT(0), .DEB_W(10)) u_dut0 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .mode8   (mode8),
        .rotate  (rotate),
        .dir_in  (dir_in),
        .dir_out (out0),
        .changed (chg0)
    );

    joy_dir_arbiter #(.NUM_CH(NCH), .DEB_CNT(4), .DEB_W(3)) u_dut4 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .mode8   (mode8),
        .rotate  (rotate),
        .dir_in  (dir_in),
        .dir_out (out4),
        .changed (chg4)
    );

    // Model state, indexed [instance][channel]; instance 0 = no debounce, 1 = 4 ticks.
    logic [3:0] mSyncA  [2][NCH];
    logic [3:0] mSyncB  [2][NCH];
    logic [3:0] mStable [2][NCH];
    logic [3:0] mPrev   [2][NCH];
    logic [3:0] mOut    [2][NCH];
    logic       mChg    [2][NCH];
    int         mAge    [2][NCH][4];
    int         mOwner  [2][NCH];
    int         debTicks[2] = '{0, 4};

    // Rotated cabinet: up<-left, down<-right, left<-down, right<-up.
    function automatic logic [3:0] rotDir(logic [3:0] d);
        return {d[1], d[0], d[2], d[3]};
    endfunction

    // Highest-priority set bit index (up=3 first), -1 when nothing is held.
    function automatic int topBit(logic [3:0] d);
        for (int i = 3; i >= 0; i--) begin
            if (d[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                mSyncA[m][c]  = '0;
                mSyncB[m][c]  = '0;
                mStable[m][c] = '0;
                mPrev[m][c]   = '0;
                mOut[m][c]    = '0;
                mChg[m][c]    = 1'b0;
                mOwner[m][c]  = -1;
                for (int b = 0; b < 4; b++) mAge[m][c][b] = 0;
            end
        end
    endtask

    // One clock of behaviour, computed from the values held before the edge.
    task automatic modelStep();
        logic [3:0] raw, held, rise, o, nextHeld;
        int         owner;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                raw   = dir_in[4*c +: 4];
                held  = mStable[m][c];
                rise  = held & ~mPrev[m][c];
                owner = mOwner[m][c];
                if (rise != 4'b0) owner = topBit(rise);
                else if (owner < 0 || !held[owner]) owner = topBit(held);
                if (mode8) begin
                    o = held;
                    if (o[3] && o[2]) o[3:2] = 2'b00;
                    if (o[1] && o[0]) o[1:0] = 2'b00;
                end else begin
                    o = (owner >= 0) ? (held & (4'b0001 << owner)) : 4'b0000;
                end
                mChg[m][c]   = (o != mOut[m][c]);
                mOut[m][c]   = o;
                mOwner[m][c] = owner;
                mPrev[m][c]  = held;

                // A differing bit is adopted once it has persisted for the
                // required number of ce ticks.
                nextHeld = held;
                for (int b = 0; b < 4; b++) begin
                    if (mSyncB[m][c][b] == held[b]) begin
                        mAge[m][c][b] = 0;
                    end else if (debTicks[m] == 0) begin
                        nextHeld[b] = mSyncB[m][c][b];
                    end else if (ce) begin
                        mAge[m][c][b] = mAge[m][c][b] + 1;
                        if (mAge[m][c][b] == debTicks[m]) begin
                            nextHeld[b]   = mSyncB[m][c][b];
                            mAge[m][c][b] = 0;
                        end
                    end
                end
                mStable[m][c] = nextHeld;
                mSyncB[m][c]  = mSyncA[m][c];
                mSyncA[m][c]  = rotate ? rotDir(raw) : raw;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("dir_out_nodeb", out0, {mOut[0][1], mOut[0][0]});
        checkOutput("changed_nodeb", chg0, {mChg[0][1], mChg[0][0]});
        checkOutput("dir_out_deb4",  out4, {mOut[1][1], mOut[1][0]});
        checkOutput("changed_deb4",  chg4, {mChg[1][1], mChg[1][0]});
    endtask

    task automatic applyStimulus(input logic [7:0] dirs, input logic m8, input logic rot,
                                 input logic ceVal, input int n);
        dir_in = dirs;
        mode8  = m8;
        rotate = rot;
        ce     = ceVal;
        repeat (n) begin
            @(posedge clk_sys);
            modelStep();
            #1;
            compareAll();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        mode8   = 1'b0;
        rotate  = 1'b0;
        dir_in  = '0;
        modelReset();
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("reset_out0", out0, 8'h00);
        checkOutput("reset_chg0", chg0, 2'b00);
        checkOutput("reset_out4", out4, 8'h00);
        #3 reset_n = 1'b1;

        // Newest press wins, fallback to still-held direction on release.
        applyStimulus(8'h00, 0, 0, 1, 6);
        applyStimulus(8'h01, 0, 0, 1, 4);
        checkOutput("t1_right", out0[3:0], 4'b0001);
        checkOutput("t1_right_chg", chg0[0], 1'b1);
        applyStimulus(8'h09, 0, 0, 1, 4);
        checkOutput("t1_up", out0[3:0], 4'b1000);
        checkOutput("t1_up_chg", chg0[0], 1'b1);
        applyStimulus(8'h01, 0, 0, 1, 4);
        checkOutput("t1_fallback", out0[3:0], 4'b0001);
        checkOutput("t1_fallback_chg", chg0[0], 1'b1);
        applyStimulus(8'h00, 0, 0, 1, 4);
        checkOutput("t1_release", out0[3:0], 4'b0000);
        checkOutput("t1_release_chg", chg0[0], 1'b1);

        // Short glitch is rejected by the debounce; a long press gets through.
        applyStimulus(8'h00, 0, 0, 1, 10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h02, 0, 0, 1, 1);
            checkOutput("t2_glitch", out4[3:0], 4'b0000);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h00, 0, 0, 1, 1);
            checkOutput("t2_glitch_after", out4[3:0], 4'b0000);
        end
        applyStimulus(8'h02, 0, 0, 1, 10);
        checkOutput("t2_press", out4[3:0], 4'b0010);
        applyStimulus(8'h00, 0, 0, 1, 10);

        // Simultaneous rise, live switch to 8-way, opposite cancel.
        applyStimulus(8'h0A, 0, 0, 1, 4);
        checkOutput("t3_simul", out0[3:0], 4'b1000);
        applyStimulus(8'h0A, 1, 0, 1, 1);
        checkOutput("t3_mode8", out0[3:0], 4'b1010);
        applyStimulus(8'h0C, 1, 0, 1, 8);
        checkOutput("t3_cancel0", out0[3:0], 4'b0000);
        checkOutput("t3_cancel4", out4[3:0], 4'b0000);

        // Rotation with both channels driven independently.
        applyStimulus(8'h00, 0, 0, 1, 10);
        applyStimulus(8'h12, 0, 1, 1, 8);
        checkOutput("t4_rot0", out0, 8'h48);
        checkOutput("t4_rot4", out4, 8'h48);
        applyStimulus(8'h82, 0, 1, 1, 8);
        checkOutput("t4_ch1_only", out0, 8'h18);

        // Asynchronous reset in the middle of a debounce.
        applyStimulus(8'h02, 0, 0, 1, 10);
        applyStimulus(8'h01, 0, 0, 1, 4);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_out0", out0, 8'h00);
        checkOutput("t5_rst_out4", out4, 8'h00);
        checkOutput("t5_rst_chg0", chg0, 2'b00);
        checkOutput("t5_rst_chg4", chg4, 2'b00);
        modelReset();
        repeat (2) @(posedge clk_sys);
        #3 reset_n = 1'b1;
        applyStimulus(8'h01, 0, 0, 1, 3);
        checkOutput("t5_early", out0[3:0], 4'b0000);
        applyStimulus(8'h01, 0, 0, 1, 1);
        checkOutput("t5_reacq0", out0[3:0], 4'b0001);
        applyStimulus(8'h01, 0, 0, 1, 6);
        checkOutput("t5_reacq4", out4[3:0], 4'b0001);

        // Random traffic with occasional mode/rotate flips and sparse ce.
        begin
            logic m8, rot;
            m8  = 1'b0;
            rot = 1'b0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 7) == 0) m8 = ~m8;
                if ($urandom_range(0, 9) == 0) rot = ~rot;
                applyStimulus(8'($urandom), m8, rot, ($urandom_range(0, 3) != 0),
                              int'($urandom_range(1, 10)));
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
